// File: rtl/tile_stats_accum.sv
// rtl/tile_stats_accum.sv - per-tile sum/mean/min/max over a tile-ordered pixel stream
// Results leave through a single-entry valid/ready register; late results are dropped and flagged.
`timescale 1ns/1ps
module tile_stats_accum #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_WIDTH  = 16,
  parameter int TILE_HEIGHT = 16,
  parameter int NUM_TILES_X = 40,
  parameter int NUM_TILES_Y = 30,
  localparam int PIX   = TILE_WIDTH * TILE_HEIGHT,
  localparam int PIX_W = $clog2(PIX),
  localparam int SUM_W = DATA_WIDTH + PIX_W,
  localparam int X_W   = (NUM_TILES_X > 1) ? $clog2(NUM_TILES_X) : 1,
  localparam int Y_W   = (NUM_TILES_Y > 1) ? $clog2(NUM_TILES_Y) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic                  iValid,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iReady,
  output logic                  oTileValid,
  output logic [X_W-1:0]        oTileX,
  output logic [Y_W-1:0]        oTileY,
  output logic [SUM_W-1:0]      oSum,
  output logic [DATA_WIDTH-1:0] oMean,
  output logic [DATA_WIDTH-1:0] oMin,
  output logic [DATA_WIDTH-1:0] oMax,
  output logic                  oFrameDone,
  output logic                  oOverflow,
  output logic                  oBusy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [PIX_W-1:0]      pix_cnt;
  logic [SUM_W-1:0]      acc_sum;
  logic [DATA_WIDTH-1:0] acc_min;
  logic [DATA_WIDTH-1:0] acc_max;
  logic [X_W-1:0]        tile_x;
  logic [Y_W-1:0]        tile_y;

  logic                  take;
  logic                  first_pix;
  logic                  last_pix;
  logic                  last_tile;
  logic                  tile_done;
  logic                  out_free;
  logic [SUM_W-1:0]      sum_nxt;
  logic [DATA_WIDTH-1:0] min_nxt;
  logic [DATA_WIDTH-1:0] max_nxt;

  // iStart has priority: a pixel arriving with it belongs to no frame.
  assign take      = (state == S_ACCUM) && iValid && !iStart;
  assign first_pix = (pix_cnt == '0);
  assign last_pix  = (pix_cnt == PIX_W'(PIX - 1));
  assign last_tile = (tile_x == X_W'(NUM_TILES_X - 1)) && (tile_y == Y_W'(NUM_TILES_Y - 1));
  assign tile_done = take && last_pix;
  assign out_free  = !oTileValid || iReady;

  assign sum_nxt = (first_pix ? '0 : acc_sum) + SUM_W'(iData);
  assign min_nxt = (first_pix || (iData < acc_min)) ? iData : acc_min;
  assign max_nxt = (first_pix || (iData > acc_max)) ? iData : acc_max;

  assign oBusy = (state == S_ACCUM);
  assign oMean = oSum[SUM_W-1:PIX_W];

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      acc_sum    <= '0;
      acc_min    <= '0;
      acc_max    <= '0;
      tile_x     <= '0;
      tile_y     <= '0;
      oFrameDone <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;
      if (iStart) begin
        state     <= S_ACCUM;
        pix_cnt   <= '0;
        acc_sum   <= '0;
        acc_min   <= '0;
        acc_max   <= '0;
        tile_x    <= '0;
        tile_y    <= '0;
        oOverflow <= 1'b0;
      end else if (take) begin
        acc_sum <= sum_nxt;
        acc_min <= min_nxt;
        acc_max <= max_nxt;
        if (last_pix) begin
          // Counter wraps to zero so the very next pixel re-initialises the accumulators.
          pix_cnt <= '0;
          if (tile_x == X_W'(NUM_TILES_X - 1)) begin
            tile_x <= '0;
            tile_y <= (tile_y == Y_W'(NUM_TILES_Y - 1)) ? '0 : tile_y + 1'b1;
          end else begin
            tile_x <= tile_x + 1'b1;
          end
          if (last_tile) begin
            state      <= S_DONE;
            oFrameDone <= 1'b1;
          end
          if (!out_free) begin
            oOverflow <= 1'b1;
          end
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  // A load in the same cycle as an accept wins, keeping oTileValid high.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oTileValid <= 1'b0;
      oTileX     <= '0;
      oTileY     <= '0;
      oSum       <= '0;
      oMin       <= '0;
      oMax       <= '0;
    end else if (tile_done && out_free) begin
      oTileValid <= 1'b1;
      oTileX     <= tile_x;
      oTileY     <= tile_y;
      oSum       <= sum_nxt;
      oMin       <= min_nxt;
      oMax       <= max_nxt;
    end else if (oTileValid && iReady) begin
      oTileValid <= 1'b0;
    end
  end

endmodule

// File: doc/tile_stats_accum.md
# tile_stats_accum

Per-tile statistics engine directly downstream of the tiled BRAM read-out stage. It consumes the tile-ordered pixel stream (16x16 tiles, raster order of tiles across a 640x480 frame). For each completed tile it produces the sum, mean, minimum and maximum, tagged with tile coordinates. Results are presented through a single-entry valid/ready output register to the contrast/threshold stages that follow.

## Interface
- DATA_WIDTH, 8, pixel width
- TILE_WIDTH, 16, pixels per tile row; must be a power of two
- TILE_HEIGHT, 16, rows per tile; must be a power of two
- NUM_TILES_X, 40, tiles per tile-row
- NUM_TILES_Y, 30, tile-rows per frame
- iClk  in  1  clock
- iRst  in  1  reset, asynchronous, active-low
- iStart  in  1  one-cycle pulse; arms or re-arms frame accumulation
- iValid  in  1  qualifies iData in the same cycle
- iData  in  DATA_WIDTH  pixel, tile order
- iReady  in  1  downstream accepts result when high with oTileValid
- oTileValid  out  1  result register holds an unconsumed result
- oTileX  out  clog2(NUM_TILES_X)  x index of reported tile
- oTileY  out  clog2(NUM_TILES_Y)  y index of reported tile
- oSum  out  DATA_WIDTH+clog2(TILE_WIDTH*TILE_HEIGHT)  pixel sum (16 bits at defaults)
- oMean  out  DATA_WIDTH  oSum >> clog2(TILE_WIDTH*TILE_HEIGHT), truncating
- oMin, oMax  out  DATA_WIDTH  tile extrema
- oFrameDone  out  1  one-cycle pulse when the last tile of the frame is registered
- oOverflow  out  1  sticky; a result was lost to backpressure
- oBusy  out  1  high in ACCUM

## Operation
- States: IDLE, ACCUM, DONE. Reset enters IDLE.
- IDLE: iValid ignored. iStart moves to ACCUM and clears the pixel, tile and accumulator state.
- ACCUM: each iValid cycle updates the running sum, min and max, and increments the pixel counter (0..TILE_WIDTH*TILE_HEIGHT-1).
  - First pixel of a tile initialises min and max to that pixel.
  - Sum is cleared on tile start. No saturation; the width is exact.
- Tile completion, on the iValid cycle carrying the last pixel:
  - Final values, including that pixel, are captured into the result register.
  - Accumulators restart, so the next iValid cycle begins the next tile with no bubble.
  - The tile counter advances x first, then y, wrapping x at NUM_TILES_X.
- Last tile of the frame (x=NUM_TILES_X-1, y=NUM_TILES_Y-1): completion pulses oFrameDone and moves to DONE.
- DONE: iValid ignored. iStart re-arms as from IDLE. The result register still drains normally.
- iStart in ACCUM restarts the frame; the partial tile is discarded and the result register is untouched.
- Output register:
  - Loaded on tile completion.
  - Cleared when oTileValid && iReady.
  - If completion coincides with an accept in the same cycle, the load wins and oTileValid stays 1.
  - If completion occurs while oTileValid=1 and iReady=0, the new result is dropped, the old one is retained and oOverflow is set.
- oOverflow clears only on reset or iStart.

## Timing
- Reset values: oTileValid=0, oFrameDone=0, oOverflow=0, oBusy=0, oTileX=0, oTileY=0, oSum=0, oMean=0, oMin=0, oMax=0.
- Latency: last pixel of a tile on cycle N gives oTileValid=1 with stable data on cycle N+1.
- oFrameDone is asserted on cycle N+1 of the last tile, for exactly one cycle.
- iStart on cycle N gives oBusy=1 at N+1. The first pixel accepted is on cycle N+1.
- Gaps in iValid stall accumulation without loss of state.
- Result data is constant while oTileValid=1 and not accepted.

## Test plan
- iStart, then 256 pixels of 0x40 with iValid held high, iReady=1 -> one result at tile (0,0): oSum=0x4000, oMean=0x40, oMin=0x40, oMax=0x40.
- Tile of ramp 0..255 -> oSum=0x7F80, oMean=0x7F, oMin=0x00, oMax=0xFF. The next tile of 0xFF gives oSum=0xFF00, oMin=0xFF, proving min/max reinitialise.
- Full frame of 1200 tiles, iValid randomly gapped, iReady=1:
  - 1200 results arrive, with tile indices stepping (0,0),(1,0)..(39,0),(0,1)..(39,29).
  - oFrameDone pulses once with tile (39,29).
  - Subsequent iValid is ignored.
- iReady=0 across two tile completions -> the first result is held unchanged, oOverflow=1. Raising iReady drains exactly one result.
- Tile completion in the same cycle as an accept -> oTileValid stays 1 carrying the new tile, and oOverflow stays 0.
- iRst low mid-tile, or iStart mid-frame -> all outputs return to reset values (the iStart case keeps the result register). A fresh 256-pixel tile then reports tile (0,0) with correct stats.
